// File: rtl/mem_arbiter_pkg.sv
// Shared widths and source encoding for the fetch / load-store memory arbiter.
package mem_arb_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_D  = 1'b1
   } src_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port seen by mem_arbiter.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a fixed-priority override for the d port.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_if_i,
   input  logic req_d_i,
   input  logic prio_d_i,
   output logic gnt_if_o,
   output logic gnt_d_o
);
   src_e rr_last_q, rr_last_d;

   // On a conflict the port that did not win last time goes first.
   always_comb begin
      gnt_if_o = 1'b0;
      gnt_d_o  = 1'b0;
      if (rst_n) begin
         if (req_if_i && req_d_i) begin
            if (prio_d_i || (rr_last_q == SRC_IF)) gnt_d_o = 1'b1;
            else                                   gnt_if_o = 1'b1;
         end else begin
            gnt_if_o = req_if_i;
            gnt_d_o  = req_d_i;
         end
      end
   end

   always_comb begin
      rr_last_d = rr_last_q;
      if (gnt_if_o)     rr_last_d = SRC_IF;
      else if (gnt_d_o) rr_last_d = SRC_D;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_last_q <= SRC_D;
      else        rr_last_q <= rr_last_d;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares a synchronous-read memory between fetch and load/store; read data
// returns to the issuing port two cycles after its grant.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter bit PRIO_DATA = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus,
   output logic [7:0]    stall_cnt
);
   logic              gnt_if, gnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              issue_v_q, issue_v_d;
   src_e              issue_src_q, issue_src_d;
   logic              resp_v_q;
   src_e              resp_src_q;
   logic [7:0]        stall_cnt_q, stall_cnt_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_if_i (bus.if_req),
      .req_d_i  (bus.d_req),
      .prio_d_i (PRIO_DATA),
      .gnt_if_o (gnt_if),
      .gnt_d_o  (gnt_d)
   );

   always_comb begin
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      issue_v_d   = gnt_if | gnt_d;
      issue_src_d = gnt_d ? SRC_D : SRC_IF;
      if (gnt_d) begin
         mem_we_d    = bus.d_we;
         mem_addr_d  = bus.d_addr;
         mem_wdata_d = bus.d_wdata;
      end else if (gnt_if) begin
         mem_addr_d  = bus.if_addr;
      end
      stall_cnt_d = stall_cnt_q;
      if ((bus.if_req & ~gnt_if) | (bus.d_req & ~gnt_d)) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   // Issue stage drives the memory port; response stage marks when mem_rdata is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         issue_v_q   <= 1'b0;
         issue_src_q <= SRC_IF;
         resp_v_q    <= 1'b0;
         resp_src_q  <= SRC_IF;
         stall_cnt_q <= 8'd0;
      end else begin
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         issue_v_q   <= issue_v_d;
         issue_src_q <= issue_src_d;
         resp_v_q    <= issue_v_q;
         resp_src_q  <= issue_src_q;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.if_gnt    = gnt_if;
   assign bus.d_gnt     = gnt_d;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rvalid = resp_v_q & (resp_src_q == SRC_IF);
   assign bus.d_rvalid  = resp_v_q & (resp_src_q == SRC_D);
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;
   assign stall_cnt     = stall_cnt_q;

   no_double_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_if && gnt_d));
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a behavioural memory reference.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
   logic [7:0] stall0, stall1;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_DATA(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(b0), .stall_cnt(stall0));
   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_DATA(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(b1), .stall_cnt(stall1));

   // Synchronous-read memories; preload port used only while pre_en is high.
   logic       pre_en;
   logic [7:0] pre_addr, pre_data;
   logic [7:0] mem0 [256];
   logic [7:0] mem1 [256];
   always_ff @(posedge clk) begin
      if (pre_en) begin
         mem0[pre_addr] <= pre_data;
         mem1[pre_addr] <= pre_data;
      end else begin
         if (b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
         if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      end
      b0.mem_rdata <= mem0[b0.mem_addr];
      b1.mem_rdata <= mem1[b1.mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_all();
      b0.if_req = 1'b0; b0.if_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0;
      b0.d_addr = '0;   b0.d_wdata = '0;
      b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
      b1.d_addr = '0;   b1.d_wdata = '0;
   endtask

   // Reference model for the random phase: spec-level memory and response queue.
   typedef struct {
      logic       src_d;
      logic       we;
      logic [7:0] data;
      int         due;
   } rsp_t;
   rsp_t       rq[$];
   rsp_t       r;
   logic [7:0] ref_mem [256];
   logic       last_d, if_pend, d_pend, exp_if, exp_d;
   int         stall_exp;

   task automatic rand_cycle(input int c, input bit gen);
      next();
      if (!gen) begin
         b0.if_req = 1'b0;
         b0.d_req  = 1'b0;
      end else begin
         if (!(if_pend && $urandom_range(0, 19) != 0)) begin
            b0.if_req  = ($urandom_range(0, 99) < 60);
            b0.if_addr = 8'($urandom_range(0, 15));
         end
         if (!(d_pend && $urandom_range(0, 19) != 0)) begin
            b0.d_req   = ($urandom_range(0, 99) < 60);
            b0.d_we    = $urandom_range(0, 1) == 1;
            b0.d_addr  = 8'($urandom_range(0, 15));
            b0.d_wdata = 8'($urandom);
         end
      end
      smp();
      exp_if = b0.if_req && (!b0.d_req || last_d);
      exp_d  = b0.d_req && (!b0.if_req || !last_d);
      chk("rand_gnt", {30'd0, b0.if_gnt, b0.d_gnt}, {30'd0, exp_if, exp_d});
      chk("rand_stall", {24'd0, stall0}, stall_exp);
      if (rq.size() > 0 && rq[0].due == c) begin
         r = rq.pop_front();
         chk("rand_rvalid", {30'd0, b0.if_rvalid, b0.d_rvalid}, {30'd0, !r.src_d, r.src_d});
         if (!r.src_d)    chk("rand_if_rdata", {24'd0, b0.if_rdata}, {24'd0, r.data});
         else if (!r.we)  chk("rand_d_rdata", {24'd0, b0.d_rdata}, {24'd0, r.data});
      end else begin
         chk("rand_no_rvalid", {30'd0, b0.if_rvalid, b0.d_rvalid}, 32'd0);
      end
      if (exp_if) begin
         rq.push_back('{1'b0, 1'b0, ref_mem[b0.if_addr], c + 2});
         last_d = 1'b0;
      end else if (exp_d) begin
         if (b0.d_we) ref_mem[b0.d_addr] = b0.d_wdata;
         rq.push_back('{1'b1, b0.d_we, ref_mem[b0.d_addr], c + 2});
         last_d = 1'b1;
      end
      if (((b0.if_req && !exp_if) || (b0.d_req && !exp_d)) && stall_exp < 255) stall_exp++;
      if_pend = b0.if_req && !exp_if;
      d_pend  = b0.d_req && !exp_d;
   endtask

   initial begin
      idle_all();
      rst_n = 1'b0; pre_en = 1'b1; pre_addr = '0; pre_data = '0;
      b0.if_req = 1'b1; b0.d_req = 1'b1;
      for (int i = 0; i < 256; i++) begin
         next();
         pre_addr = 8'(i);
         pre_data = (i == 5) ? 8'h75 : 8'($urandom);
      end
      next();
      pre_en = 1'b0;
      smp();
      chk("rst_if_gnt", b0.if_gnt, 0);
      chk("rst_d_gnt", b0.d_gnt, 0);
      chk("rst_mem_we", b0.mem_we, 0);
      chk("rst_mem_addr", b0.mem_addr, 0);
      chk("rst_mem_wdata", b0.mem_wdata, 0);
      chk("rst_rvalid", {b0.if_rvalid, b0.d_rvalid}, 0);
      chk("rst_stall", stall0, 0);
      idle_all();
      next();
      rst_n = 1'b1;

      // Single fetch from address 5.
      next();
      b0.if_req = 1'b1; b0.if_addr = 8'h05;
      smp();
      chk("fetch_gnt", {b0.if_gnt, b0.d_gnt}, 2'b10);
      next();
      b0.if_req = 1'b0;
      smp();
      chk("fetch_mem_addr", b0.mem_addr, 8'h05);
      chk("fetch_mem_we", b0.mem_we, 0);
      chk("fetch_early_rvalid", b0.if_rvalid, 0);
      next(); smp();
      chk("fetch_rvalid", {b0.if_rvalid, b0.d_rvalid}, 2'b10);
      chk("fetch_rdata", b0.if_rdata, 8'h75);
      next(); smp();
      chk("fetch_rvalid_pulse", b0.if_rvalid, 0);

      // Store then load to the same address back to back.
      next();
      b0.d_req = 1'b1; b0.d_we = 1'b1; b0.d_addr = 8'h0F; b0.d_wdata = 8'h3C;
      smp();
      chk("st_gnt", b0.d_gnt, 1);
      next();
      b0.d_we = 1'b0;
      smp();
      chk("ld_gnt", b0.d_gnt, 1);
      chk("st_mem_we", b0.mem_we, 1);
      chk("st_mem_addr", b0.mem_addr, 8'h0F);
      chk("st_mem_wdata", b0.mem_wdata, 8'h3C);
      next();
      b0.d_req = 1'b0;
      smp();
      chk("st_mem_we_pulse", b0.mem_we, 0);
      chk("st_rvalid", {b0.if_rvalid, b0.d_rvalid}, 2'b01);
      next(); smp();
      chk("ld_rvalid", b0.d_rvalid, 1);
      chk("ld_rdata", b0.d_rdata, 8'h3C);
      next(); smp();
      chk("ld_rvalid_pulse", b0.d_rvalid, 0);

      // Continuous conflict, round-robin instance.
      for (int k = 0; k < 8; k++) begin
         next();
         b0.if_req = 1'b1; b0.if_addr = 8'h05;
         b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 8'h0F;
         smp();
         chk("rr_gnt", {b0.if_gnt, b0.d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         chk("rr_stall", stall0, k);
      end
      next();
      b0.if_req = 1'b0; b0.d_req = 1'b0;
      smp();
      chk("rr_stall_end", stall0, 8);
      repeat (3) next();

      // Continuous conflict, fixed-priority instance; stall counter saturates.
      for (int k = 0; k < 300; k++) begin
         next();
         b1.if_req = 1'b1; b1.if_addr = 8'h01;
         b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 8'h02;
         smp();
         chk("prio_gnt", {b1.if_gnt, b1.d_gnt}, 2'b01);
         chk("prio_stall", stall1, (k > 255) ? 255 : k);
      end
      next();
      b1.if_req = 1'b0; b1.d_req = 1'b0;
      smp();
      chk("prio_stall_sat", stall1, 255);
      repeat (3) next();

      // Reset one cycle after a load grant.
      next();
      b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 8'h0F;
      smp();
      chk("rl_gnt", b0.d_gnt, 1);
      next();
      b0.d_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rl_mem_we", b0.mem_we, 0);
      chk("rl_mem_addr", b0.mem_addr, 0);
      chk("rl_mem_wdata", b0.mem_wdata, 0);
      chk("rl_rvalid", {b0.if_rvalid, b0.d_rvalid}, 0);
      chk("rl_stall", stall0, 0);
      next();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         next(); smp();
         chk("rl_no_rvalid", {b0.if_rvalid, b0.d_rvalid}, 0);
      end
      next();
      b0.if_req = 1'b1; b0.if_addr = 8'h05; b0.d_req = 1'b1; b0.d_addr = 8'h0F;
      smp();
      chk("rl_first_conflict", {b0.if_gnt, b0.d_gnt}, 2'b10);
      next();
      b0.if_req = 1'b0;
      smp();
      chk("rl_second", {b0.if_gnt, b0.d_gnt}, 2'b01);
      next();
      b0.d_req = 1'b0;
      repeat (3) next();

      // Random legal traffic against the reference model.
      rst_n = 1'b0;
      next(); next();
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem0[i];
      last_d = 1'b1; if_pend = 1'b0; d_pend = 1'b0; stall_exp = 0;
      for (int c = 0; c < 10000; c++) rand_cycle(c, 1'b1);
      for (int c = 10000; c < 10004; c++) rand_cycle(c, 1'b0);
      chk("rand_drained", rq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter sharing the single-port, synchronous-read 256x8 program/data memory between the CPU instruction-fetch unit and the load/store unit. It accepts one request per cycle, registers the winning access onto the memory port and returns the read data two cycles after grant to the requester that issued it. It sits between the CPU core and the memory and is the only driver of the memory's write_enable, address and write_data.

Parameters:
ADDR_W, 8, address width; matches the memory depth of 256.
DATA_W, 8, data width.
PRIO_DATA, 0, 0 = round-robin between ports; 1 = load/store port always wins.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request; held with if_addr until if_gnt.
if_addr  in  ADDR_W  fetch address.
if_gnt  out  1  fetch accepted this cycle (combinational).
if_rvalid  out  1  fetch data valid.
if_rdata  out  DATA_W  fetch data.
d_req  in  1  load/store request; held with d_we, d_addr, d_wdata until d_gnt.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  load/store address.
d_wdata  in  DATA_W  store data.
d_gnt  out  1  load/store accepted this cycle (combinational).
d_rvalid  out  1  load/store response (load data or store ack).
d_rdata  out  DATA_W  load data.
mem_we  out  1  to memory write_enable (registered).
mem_addr  out  ADDR_W  to memory address (registered).
mem_wdata  out  DATA_W  to memory write_data (registered).
mem_rdata  in  DATA_W  from memory read_data (one-cycle synchronous read).
stall_cnt  out  8  saturating count of cycles where a request was pending but not granted.

Behaviour:
- Reset: async, active-low. While rst_n = 0: if_gnt = d_gnt = 0; mem_we, mem_addr and mem_wdata = 0; both rvalid = 0; stall_cnt = 0; rr_last = DATA, so fetch wins the first conflict. In-flight accesses are discarded, with no rvalid after reset release. Memory contents are not affected.
- Grant, in cycle N, combinational:
  - Only one requester: it is granted.
  - Both requesting, PRIO_DATA = 0: the port not granted last is granted.
  - Both requesting, PRIO_DATA = 1: d is granted.
  - No request: no grant.
- rr_last updates on every grant.
- Issue, at the edge ending cycle N: mem_addr and mem_wdata latch the winner's operands; mem_we = d_we if d won, else 0. issue_v and issue_src are latched.
- With no grant: mem_we = 0, and mem_addr and mem_wdata hold their previous values.
- Memory access occurs at the edge ending cycle N+1.
- Response in cycle N+2:
  - The rvalid of the issuing port is high for exactly one cycle.
  - rdata = mem_rdata, passed through; the other port's rdata is don't-care.
  - Store responses pulse d_rvalid with d_rdata undefined (pre-write contents); the requester ignores it.
- Latency: grant to rvalid = 2 cycles. Throughput: one grant per cycle, sustained.
- Responses have no backpressure; requesters always accept rvalid.
- Ordering: responses return in grant order. A store granted in N followed by a load to the same address granted in N+1 returns the new data.
- Handshake rule: request signals may change only in the cycle after gnt. A dropped request without gnt is legal and consumes nothing.
- stall_cnt: +1 on each cycle where (if_req & ~if_gnt) | (d_req & ~d_gnt), saturating at 255.
- Simultaneous grant on both ports never occurs (verified by assertion).

Decomposition:
- Package mem_arb_pkg holds ADDR_W and DATA_W defaults and the source encoding SRC_IF = 0, SRC_D = 1.
- One sub-module, rr_arb2: a two-requester round-robin grant with an rr_last register and a fixed-priority override input.
- Issue/response pipeline registers and stall_cnt stay in mem_arbiter.

Test Plan:
- Preload memory with mem[5] = 0x75. Fetch only, if_addr = 5 at cycle 1. Required: if_gnt at 1, mem_addr = 5 at 2, if_rvalid with if_rdata = 0x75 at 3.
- Store 0x3C to 0x0F, then load 0x0F in back-to-back cycles. Required: mem_we high for one cycle; load returns 0x3C; d_rvalid pulses at 2-cycle latency for both.
- Both ports requesting continuously, PRIO_DATA = 0. Required: grants alternate IF, D, IF, D starting with IF after reset; stall_cnt increments every cycle.
- Same traffic with PRIO_DATA = 1. Required: d_gnt every cycle and if_gnt never. Hold stall for 300 cycles: stall_cnt saturates at 255.
- Assert rst_n low one cycle after a load grant. Required: mem_we = 0 and rvalid = 0 immediately; no response after release; first conflict after release goes to IF.
- Random legal traffic of 10k cycles against a reference memory model. Required: all read data matches the model, responses come back in order, and no double grant occurs.
